// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared constants and types for the byte transmit scheduler.
//   BYTE_W          - width of one requester byte
//   FRAME_BITS      - serial frame length (start + 8 data + stop)
//   DEFAULT_NUM_REQ - default number of requesters
//   state_t         - scheduler FSM state encoding
//   frame_cycles()  - clock cycles taken by one serial frame
package tx_sched_pkg;

  localparam int BYTE_W          = 8;
  localparam int FRAME_BITS      = 10;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  function automatic int frame_cycles(input int baud_div);
    return FRAME_BITS * baud_div;
  endfunction

endpackage

// File: rtl/serial_tx.sv
// serial_tx: 8N1 serializer. A one-cycle trigger_in loads val_in; the line
// then carries start bit, 8 data bits LSB first and a stop bit, each held
// for BAUD_DIV cycles. The first start-bit cycle is the cycle after trigger.
// Ports:
//   clk_in     - clock, rising edge
//   rst_in     - synchronous active-high reset (line returns to idle 1)
//   trigger_in - load pulse
//   val_in     - byte to send, sampled on trigger_in
//   data_out   - registered serial line, idle high
module serial_tx
  import tx_sched_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              trigger_in,
  input  logic [BYTE_W-1:0] val_in,
  output logic              data_out
);

  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W  = $clog2(FRAME_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  // Holds the bits still to be shifted out after the start bit: data then stop.
  logic [FRAME_BITS-2:0] shift_reg;
  logic [BAUD_W-1:0]     baud_reg;
  logic [BIT_W-1:0]      bits_left_reg;
  logic                  active_reg;
  logic                  line_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shift_reg     <= '1;
      baud_reg      <= '0;
      bits_left_reg <= '0;
      active_reg    <= 1'b0;
      line_reg      <= 1'b1;
    end else if (trigger_in) begin
      shift_reg     <= {1'b1, val_in};
      baud_reg      <= '0;
      bits_left_reg <= BIT_W'(FRAME_BITS - 1);
      active_reg    <= 1'b1;
      line_reg      <= 1'b0;
    end else if (active_reg) begin
      if (baud_reg == BAUD_LAST) begin
        baud_reg <= '0;
        if (bits_left_reg == '0) begin
          // Stop bit has had its full period; release the line.
          active_reg <= 1'b0;
          line_reg   <= 1'b1;
        end else begin
          line_reg      <= shift_reg[0];
          shift_reg     <= {1'b1, shift_reg[FRAME_BITS-2:1]};
          bits_left_reg <= bits_left_reg - 1'b1;
        end
      end else begin
        baud_reg <= baud_reg + 1'b1;
      end
    end
  end

  assign data_out = line_reg;

endmodule

// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin arbiter feeding one serial transmitter.
// In IDLE the round-robin winner among valid requesters gets a
// combinational ready, its byte is captured, and the FSM goes TRIG (one
// trigger pulse to serial_tx) then WAIT (exactly one frame time) before
// accepting the next byte. Slots are therefore FRAME_CYCLES+2 apart.
// Optional feature: define TX_SCHED_COUNT_EN to add sent_count_out, a
// 16-bit wrapping count of issued triggers.
// Ports:
//   clk_in         - clock, rising edge
//   rst_in         - synchronous active-high reset
//   valid_in       - per-requester byte offer
//   data_in        - per-requester byte (packed array)
//   ready_out      - one-hot or zero accept, only in IDLE
//   grant_out      - one-hot owner of the byte in flight
//   busy_out       - high in TRIG and WAIT
//   sent_count_out - (TX_SCHED_COUNT_EN only) trigger count
//   data_out       - serial line
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int NUM_REQ  = DEFAULT_NUM_REQ,
  parameter int BAUD_DIV = 868
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_REQ-1:0]             valid_in,
  input  logic [NUM_REQ-1:0][BYTE_W-1:0] data_in,
  output logic [NUM_REQ-1:0]             ready_out,
  output logic [NUM_REQ-1:0]             grant_out,
  output logic                           busy_out,
`ifdef TX_SCHED_COUNT_EN
  output logic [15:0]                    sent_count_out,
`endif
  output logic                           data_out
);

  localparam int FRAME_CYCLES = frame_cycles(BAUD_DIV);
  localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);
  localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so (last_grant + k) can exceed NUM_REQ before wrapping.
  localparam int SUM_W        = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [IDX_W-1:0]      last_grant_reg, last_grant_next;
  logic [NUM_REQ-1:0]    grant_reg, grant_next;
  logic [BYTE_W-1:0]     val_q_reg, val_q_next;
  logic                  trig;

  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [SUM_W-1:0]      cand;

  // Round-robin search: first valid requester starting at last_grant+1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, last_grant_reg} + SUM_W'(k + 1);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      if (!win_found && valid_in[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Ready is only ever offered to the winner, and only while idle.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign ready_out[gi] = (state_reg == ST_IDLE) && win_found &&
                           (win_idx == IDX_W'(gi));
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    val_q_next      = val_q_reg;
    trig            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          grant_next      = NUM_REQ'(1) << win_idx;
          val_q_next      = data_in[win_idx];
          last_grant_next = win_idx;
          state_next      = ST_TRIG;
        end
      end
      ST_TRIG: begin
        trig       = 1'b1;
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // Counts 0..FRAME_CYCLES-1, so WAIT lasts exactly one frame.
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          grant_next = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      grant_reg      <= '0;
      val_q_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      val_q_reg      <= val_q_next;
    end
  end

  assign grant_out = grant_reg;
  assign busy_out  = (state_reg != ST_IDLE);

`ifdef TX_SCHED_COUNT_EN
  logic [15:0] sent_count_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sent_count_reg <= '0;
    end else if (trig) begin
      sent_count_reg <= sent_count_reg + 16'd1;
    end
  end

  assign sent_count_out = sent_count_reg;
`endif

  serial_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_serial_tx (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .trigger_in (trig),
    .val_in     (val_q_reg),
    .data_out   (data_out)
  );

endmodule
